// File: rtl/uart_tx_bus_responder.sv
// uart_tx_bus_responder: memory-mapped 8N1 UART transmitter with a transmit FIFO,
// serviced as a responder on the core data bus.
module uart_tx_bus_responder #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h1000_0000,
    parameter int          CLOCKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic        bus_hit,
    output logic [31:0] bus_data_fetched,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLOCKS_PER_BIT);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow, tx_enable;
    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          aligned, wr_hit, push, pop, accept, drop, empty, full, baud_end;
    logic [31:0]   status, reg_value;

    assign bus_hit   = bus_address[31:4] == BASE_ADDRESS[31:4];
    assign aligned   = bus_address[1:0] == 2'b00;
    assign wr_hit    = bus_write_enable && bus_hit && aligned;
    assign push      = wr_hit && bus_address[3:2] == 2'd0;
    assign empty     = count == '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign baud_end  = baud == BW'(CLOCKS_PER_BIT - 1);
    // A pop both from IDLE and at the last STOP cycle gives gapless back-to-back frames
    assign pop       = !empty && tx_enable && (state == IDLE || (state == STOP && baud_end));
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign status    = {20'd0, 4'(count), 4'd0, overflow, empty, full, state != IDLE};
    assign reg_value = !aligned ? 32'd0 :
                       bus_address[3:2] == 2'd1 ? status :
                       bus_address[3:2] == 2'd2 ? {31'd0, tx_enable} : 32'd0;

    always_comb begin
        bus_data_fetched = 32'd0;
        if (bus_hit && bus_read_enable)
            bus_data_fetched = bus_format == 3'b000 ? {{24{reg_value[7]}}, reg_value[7:0]} :
                               bus_format == 3'b001 ? {{16{reg_value[15]}}, reg_value[15:0]} :
                               bus_format == 3'b010 ? reg_value :
                               bus_format == 3'b100 ? {24'd0, reg_value[7:0]} :
                               bus_format == 3'b101 ? {16'd0, reg_value[15:0]} : 32'd0;
    end

    always_ff @(posedge clock)
        if (accept) mem[wr_ptr] <= bus_write_data[7:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            tx_enable <= 1'b1;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop) count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;
            // A drop in the same cycle as a clear leaves overflow set
            overflow <= drop ? 1'b1 :
                        (wr_hit && bus_address[3:2] == 2'd1 && bus_write_data[3]) ? 1'b0 : overflow;
            if (wr_hit && bus_address[3:2] == 2'd2) tx_enable <= bus_write_data[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    state   <= START;
                    shift   <= mem[rd_ptr];
                    uart_tx <= 1'b0;
                end
                START: if (baud_end) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    uart_tx <= shift[0];
                    shift   <= shift >> 1;
                end
                DATA: if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                    end
                end
                default: if (baud_end) begin
                    state   <= pop ? START : IDLE;
                    uart_tx <= !pop;
                    if (pop) shift <= mem[rd_ptr];
                end
            endcase
        end
    end
endmodule
